// File: rtl/encode164_scan.sv
// 16-to-4 scanning priority encoder: captures a request vector, then hands out one
// pending index per ready handshake. Define ENCODE164_LSB_PRIORITY_EN for bit-0-first order.
module encode164_scan (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] x,
  input  logic        ready,
  output logic [3:0]  y,
  output logic        valid,
  output logic        busy,
  output logic        done,
  output logic        none
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t      state_r;
  logic [15:0] pending_r;
  logic [15:0] remaining_s;

  // Index of the highest-priority set bit; later loop iterations win.
  function automatic logic [3:0] prio_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
`ifdef ENCODE164_LSB_PRIORITY_EN
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
`else
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
`endif
    return idx;
  endfunction

  // Pending bits left once the index currently on y is consumed.
  always_comb begin
    remaining_s = pending_r & ~(16'h0001 << y);
  end

  // Control FSM with registered outputs; y always mirrors the priority index of pending_r in SCAN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      pending_r <= 16'h0000;
      y         <= 4'b0000;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      none      <= 1'b0;
    end else if (!en) begin
      done <= 1'b0;
      none <= 1'b0;
    end else begin
      done <= 1'b0;
      none <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load) begin
            if (x != 16'h0000) begin
              pending_r <= x;
              y         <= prio_idx(x);
              valid     <= 1'b1;
              busy      <= 1'b1;
              state_r   <= SCAN;
            end else begin
              none <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (ready) begin
            pending_r <= remaining_s;
            if (remaining_s != 16'h0000) begin
              y <= prio_idx(remaining_s);
            end else begin
              valid   <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          pending_r <= 16'h0000;
          valid     <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encode164_scan.sv
// Directed table-driven bench for encode164_scan plus a hand-written stall sequence.
module tb_encode164_scan;

  logic        clk = 1'b0;
  logic        rst, en, load, ready;
  logic [15:0] x;
  logic [3:0]  y;
  logic        valid, busy, done, none;

  int n_vec = 0;
  int n_bad = 0;

  encode164_scan dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .x(x), .ready(ready),
    .y(y), .valid(valid), .busy(busy), .done(done), .none(none)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, load, ready;
    logic [15:0] x;
    logic [3:0]  ey;
    logic        ev, eb, ed, en_;
  } vec_t;

  vec_t tbl[27];

  // Expected index depending on priority direction: m for MSB-first, l for LSB-first.
  function automatic logic [3:0] ey(input logic [3:0] m, input logic [3:0] l);
`ifdef ENCODE164_LSB_PRIORITY_EN
    return l;
`else
    return m;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          xfers, stall, dones, stall_chk;
    logic [4:0]  exp_i;
    logic [7:0]  act_o, exp_o;

    rst = 1'b1; en = 1'b0; load = 1'b0; ready = 1'b0; x = 16'h0000;

    //          rst   en    load  ready x         y            v     b     d     n
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h8421, ey(15, 0),   1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, ey(10, 5),   1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, ey(5, 10),   1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, ey(0, 15),   1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, ey(0, 15),   1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, ey(0, 15),   1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, ey(0, 15),   1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, ey(0, 15),   1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, ey(0, 15),   1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0110, ey(8, 4),    1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, ey(8, 4),    1'b1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, ey(8, 4),    1'b1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, ey(4, 8),    1'b1, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, ey(4, 8),    1'b0, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, ey(4, 8),    1'b0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h00F0, ey(7, 4),    1'b1, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, ey(6, 5),    1'b1, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, ey(5, 6),    1'b1, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd0,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd0,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0002, 4'd1,        1'b1, 1'b1, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd1,        1'b0, 1'b0, 1'b1, 1'b0};
    tbl[24] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0001, 4'd0,        1'b1, 1'b1, 1'b0, 1'b0};
    tbl[25] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd0,        1'b0, 1'b0, 1'b1, 1'b0};
    tbl[26] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd0,        1'b0, 1'b0, 1'b0, 1'b0};

    #1;
    for (int i = 0; i < 27; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; load = tbl[i].load;
      ready = tbl[i].ready; x = tbl[i].x;
      step();
      act_o = {y, valid, busy, done, none};
      exp_o = {tbl[i].ey, tbl[i].ev, tbl[i].eb, tbl[i].ed, tbl[i].en_};
      chk($sformatf("row%0d {y,valid,busy,done,none}", i), int'(act_o), int'(exp_o));
    end

    // All-ones vector with a two-cycle enable drop after the fifth transfer.
    rst = 1'b0; en = 1'b1; load = 1'b1; ready = 1'b1; x = 16'hFFFF;
    step();
    load = 1'b0; x = 16'h0000;
    xfers = 0; stall = 2; dones = 0;
    exp_i = ey(4'd15, 4'd0);
    stall_chk = int'(ey(4'd10, 4'd5));
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (xfers == 5 && stall > 0) begin
        en = 1'b0;
        chk("stall_y", int'(y), stall_chk);
        chk("stall_valid", int'(valid), 1);
        stall--;
      end else begin
        en = 1'b1;
        if (valid) begin
          chk($sformatf("ffff_xfer%0d_y", xfers), int'(y), int'(exp_i[3:0]));
`ifdef ENCODE164_LSB_PRIORITY_EN
          exp_i = exp_i + 5'd1;
`else
          exp_i = exp_i - 5'd1;
`endif
          xfers++;
        end
      end
      step();
      if (done) dones++;
      if (xfers == 16) break;
    end
    chk("ffff_transfers", xfers, 16);
    chk("ffff_done_count", dones, 1);
    chk("ffff_end_valid_busy", int'({valid, busy}), 0);
    step();
    chk("ffff_done_drop", int'(done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/encode164_scan.md
ENCODE164_SCAN -- requirements
Module: encode164_scan

Interface
REQ-001 Parameters: none; input width fixed at 16 and index width at 4.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 en  input  1  enable; when 0, all state and outputs hold.
REQ-006 load  input  1  capture request; sampled only in IDLE with en=1.
REQ-007 x  input  16  request vector; bit i set = index i pending.
REQ-008 y  output  4  encoded index of the current pending bit; registered.
REQ-009 valid  output  1  y holds a pending index; registered.
REQ-010 ready  input  1  consumer accepts y when valid=1.
REQ-011 busy  output  1  high in SCAN state.
REQ-012 done  output  1  one-cycle pulse when the last pending index is accepted.
REQ-013 none  output  1  one-cycle pulse when a load captures x=16'h0000.

Function
REQ-014 States: IDLE, SCAN; 16-bit pending register holds unconsumed bits.
REQ-015 IDLE, en=1, load=1, x!=0: pending<=x; go to SCAN; next cycle valid=1, y=highest set index of x (load-to-valid latency 1 cycle).
REQ-016 IDLE, en=1, load=1, x=0: pending stays 0; none=1 for one cycle; stay in IDLE; valid stays 0.
REQ-017 SCAN: valid=1 and busy=1 continuously; y=priority index of pending (default bit 15 highest).
REQ-018 SCAN, en=1, valid=1, ready=1: clear bit y in pending; if remaining pending!=0, next cycle y=next priority index and valid stays 1 (one index per cycle at full throughput).
REQ-019 Accepting the last pending bit: done=1 next cycle, valid=0, busy=0, return to IDLE; y holds its last value.
REQ-020 SCAN, ready=0: y, valid, and pending hold unchanged.
REQ-021 load in SCAN: ignored; x is not sampled.
REQ-022 en=0: no state change, no handshake accepted, done/none forced to 0, and y/valid/busy hold.
REQ-023 Single-bit x (e.g. 16'h0001): exactly one transfer followed by done; no none pulse.
REQ-024 x=16'hFFFF: exactly 16 transfers, y=15..0 in order, then done.
REQ-025 done and none are never both 1; at most one of them pulses per load.

Reset
REQ-026 rst=1 at a rising edge: state<=IDLE, pending<=0, y<=4'b0000, valid<=0, busy<=0, done<=0, none<=0.
REQ-027 rst overrides en, load, and ready, including mid-SCAN; any partially consumed vector is discarded with no done pulse.

Configuration
REQ-028 Macro ENCODE164_LSB_PRIORITY_EN: when defined, priority is bit 0 highest (y ascends 0..15); when undefined, priority is bit 15 highest (y descends 15..0).
REQ-029 All other behaviour, latency, and reset values are identical with or without the macro.

Verification
REQ-030 rst=1 for 2 cycles, then en=1, load=1, x=16'h8421, ready=1 -> y=15,10,5,0 on 4 consecutive cycles with valid=1, then done=1 for 1 cycle, then busy=0.
REQ-031 en=1, load=1, x=16'h0000 -> none=1 for 1 cycle, valid=0, busy=0, state remains IDLE.
REQ-032 x=16'h0110, ready low for 3 cycles, then high -> y=8 held for 3 cycles, then y=8 accepted, y=4 accepted, done=1.
REQ-033 x=16'hFFFF with ready=1, en dropped to 0 for 2 cycles after the 5th transfer -> y holds at 10 during the stall; resumes 10..0 (16 transfers total); done=1 once.
REQ-034 x=16'h00F0 accepted, rst=1 after the 2nd transfer -> next cycle valid=0, busy=0, y=0, no done pulse; a fresh load of x=16'h0002 yields y=1, then done.
REQ-035 Build with ENCODE164_LSB_PRIORITY_EN defined, load x=16'h8421 with ready=1 -> y=0,5,10,15, then done.
